// File: rtl/ntt_bram_pkg.sv
// Shared constants, state encoding and sizing helper for the NTT BRAM host.
package ntt_bram_pkg;

    localparam int N_DEF      = 64;
    localparam int X_BASE_DEF = 0;
    localparam int Y_BASE_DEF = 64;
    localparam int W_BASE_DEF = 128;
    localparam int ADDR_W     = 15;
    localparam int DATA_W     = 64;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_X,
        LOAD_W,
        START,
        WAIT_DONE,
        READ_Y
    } state_t;

    // Word counter width large enough to hold N*N-1 without wrapping.
    function automatic int cnt_width(input int n);
        return (n * n > 1) ? $clog2(n * n) : 1;
    endfunction

endpackage

// File: rtl/ntt_bram_skid.sv
// Two-entry output buffer between the BRAM read pipeline and the host y stream.
module ntt_bram_skid
    import ntt_bram_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_valid,
    output logic              o_ready,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [1:0]        o_count
);

    logic [DATA_W-1:0] r_mem [2];
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_count;
    logic              w_push;
    logic              w_pop;

    assign o_valid = (r_count != 2'd0);
    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    // A full buffer can still take a word in the same cycle its head leaves.
    assign o_ready = (r_count != 2'd2) || i_ready;
    assign w_push  = i_valid && o_ready;
    assign w_pop   = o_valid && i_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

endmodule

// File: rtl/ntt_bram_host.sv
// Streams x and w from the host into BRAM, triggers the NTT engine, then streams y back out.
module ntt_bram_host
    import ntt_bram_pkg::*;
#(
    parameter int N      = N_DEF,
    parameter int X_BASE = X_BASE_DEF,
    parameter int Y_BASE = Y_BASE_DEF,
    parameter int W_BASE = W_BASE_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              ntt_start,
    input  logic              ntt_done,
    output logic              busy,
    output logic [ADDR_W-1:0] BRAM_addr,
    output logic              BRAM_clk,
    output logic [DATA_W-1:0] BRAM_din,
    input  logic [DATA_W-1:0] BRAM_dout,
    output logic              BRAM_en,
    output logic              BRAM_we
);

    localparam int              CNT_W  = cnt_width(N);
    localparam logic [CNT_W-1:0] X_LAST = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] W_LAST = CNT_W'(N * N - 1);
    localparam logic [CNT_W-1:0] Y_CNT  = CNT_W'(N);

    state_t            r_state;
    state_t            w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  r_pop_cnt;
    logic              r_live;
    logic              r_inflight;
    logic              w_load;
    logic              w_hs;
    logic              w_pop;
    logic              w_rd_issue;
    logic              w_skid_in_ready;
    logic [1:0]        w_occ;
    logic [ADDR_W-1:0] w_base;
    logic [ADDR_W-1:0] w_word;

    assign BRAM_clk  = clk;
    assign w_load    = (r_state == IDLE) || (r_state == LOAD_X) || (r_state == LOAD_W);
    // r_live keeps s_ready low until the first clock edge after reset.
    assign s_ready   = r_live && w_load;
    assign w_hs      = s_valid && s_ready;
    assign w_pop     = m_valid && m_ready;
    assign ntt_start = (r_state == START);
    assign busy      = (r_state != IDLE);

    // Issue only while the buffer, after this cycle's pop, can absorb every outstanding read.
    assign w_rd_issue = (r_state == READ_Y) && (r_cnt < Y_CNT) && w_skid_in_ready
                        && (({1'b0, w_occ} + {2'b0, r_inflight} - {2'b0, w_pop}) < 3'd2);

    always_comb begin
        w_base = ADDR_W'(X_BASE);
        if (r_state == LOAD_W) begin
            w_base = ADDR_W'(W_BASE);
        end else if (r_state == READ_Y) begin
            w_base = ADDR_W'(Y_BASE);
        end
    end

    assign w_word    = w_base + ADDR_W'(r_cnt);
    assign BRAM_en   = w_hs || w_rd_issue;
    assign BRAM_we   = w_hs;
    assign BRAM_din  = w_hs ? s_data : '0;
    assign BRAM_addr = BRAM_en ? (w_word << 2) : '0;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, LOAD_X: begin
                if (w_hs) begin
                    w_next = (r_cnt == X_LAST) ? LOAD_W : LOAD_X;
                end
            end
            LOAD_W: begin
                if (w_hs && (r_cnt == W_LAST)) begin
                    w_next = START;
                end
            end
            START:     w_next = WAIT_DONE;
            WAIT_DONE: begin
                if (ntt_done) begin
                    w_next = READ_Y;
                end
            end
            READ_Y: begin
                if (w_pop && (r_pop_cnt == X_LAST)) begin
                    w_next = IDLE;
                end
            end
            default:   w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_pop_cnt  <= '0;
            r_live     <= 1'b0;
            r_inflight <= 1'b0;
        end else begin
            r_live     <= 1'b1;
            r_inflight <= w_rd_issue;
            case (r_state)
                IDLE, LOAD_X: begin
                    if (w_hs) begin
                        r_cnt <= (r_cnt == X_LAST) ? '0 : r_cnt + 1'b1;
                    end
                end
                LOAD_W: begin
                    if (w_hs) begin
                        r_cnt <= (r_cnt == W_LAST) ? '0 : r_cnt + 1'b1;
                    end
                end
                READ_Y: begin
                    if (w_next == IDLE) begin
                        r_cnt <= '0;
                    end else if (w_rd_issue) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_cnt <= '0;
            endcase
            if ((r_state == READ_Y) && w_pop) begin
                r_pop_cnt <= (w_next == IDLE) ? '0 : r_pop_cnt + 1'b1;
            end else if (r_state != READ_Y) begin
                r_pop_cnt <= '0;
            end
        end
    end

    ntt_bram_skid u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_data  (BRAM_dout),
        .i_valid (r_inflight),
        .o_ready (w_skid_in_ready),
        .o_data  (m_data),
        .o_valid (m_valid),
        .i_ready (m_ready),
        .o_count (w_occ)
    );

endmodule

// File: tb/tb_ntt_bram_host.sv
// Scoreboard bench for ntt_bram_host with a behavioural BRAM and a word-list reference model.
module tb_ntt_bram_host;

    localparam int N      = 64;
    localparam int X_BASE = 0;
    localparam int Y_BASE = 64;
    localparam int W_BASE = 128;
    localparam int NW     = N * N;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [63:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [63:0] m_data;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic        ntt_start;
    logic        ntt_done = 1'b0;
    logic        busy;
    logic [14:0] BRAM_addr;
    logic        BRAM_clk;
    logic [63:0] BRAM_din;
    logic [63:0] BRAM_dout = '0;
    logic        BRAM_en;
    logic        BRAM_we;

    ntt_bram_host #(.N(N), .X_BASE(X_BASE), .Y_BASE(Y_BASE), .W_BASE(W_BASE)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .ntt_start (ntt_start),
        .ntt_done  (ntt_done),
        .busy      (busy),
        .BRAM_addr (BRAM_addr),
        .BRAM_clk  (BRAM_clk),
        .BRAM_din  (BRAM_din),
        .BRAM_dout (BRAM_dout),
        .BRAM_en   (BRAM_en),
        .BRAM_we   (BRAM_we)
    );

    // Clock / reset-independent time base
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Behavioural BRAM: synchronous write, one-cycle read latency, plus a preload port.
    logic [63:0] mem [0:8191];
    logic        pre_we = 1'b0;
    logic [12:0] pre_idx = '0;
    logic [63:0] pre_val = '0;
    always @(posedge BRAM_clk) begin
        if (pre_we) mem[pre_idx] <= pre_val;
        else if (BRAM_en && BRAM_we) mem[BRAM_addr[14:2]] <= BRAM_din;
        if (BRAM_en && !BRAM_we) BRAM_dout <= mem[BRAM_addr[14:2]];
    end

    // Scoreboard
    int n_checks = 0;
    int n_pass   = 0;
    logic [78:0] exp_q [$];
    logic [63:0] exp_y_q [$];
    logic [63:0] xs [N];
    logic [63:0] ws [NW];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    int pass_id = 0;
    int seen_id = 0;
    int n_writes, first_w_cyc, last_w_cyc, start_cyc, n_starts, n_rd, n_pop, max_out;

    always @(negedge clk) begin
        if (seen_id != pass_id) begin
            n_writes = 0; first_w_cyc = 0; last_w_cyc = 0; start_cyc = -1;
            n_starts = 0; n_rd = 0; n_pop = 0; max_out = 0;
            seen_id = pass_id;
        end
        if (!rst) begin
            if (BRAM_en && BRAM_we) begin
                if (n_writes == 0) first_w_cyc = cyc;
                last_w_cyc = cyc;
                n_writes++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write", BRAM_addr, BRAM_din);
                end else begin
                    check("bram_write", {BRAM_addr, BRAM_din}, exp_q.pop_front());
                end
            end
            if (BRAM_en && !BRAM_we) n_rd++;
            if (ntt_start) begin
                n_starts++;
                start_cyc = cyc;
            end
            if (m_valid && m_ready) begin
                n_pop++;
                if (exp_y_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_y: got 0x%0h, expected no word", m_data);
                end else begin
                    check("y_word", m_data, exp_y_q.pop_front());
                end
            end
            if (n_rd - n_pop > max_out) max_out = n_rd - n_pop;
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [14:0] addr, input logic [63:0] d, input int gaps);
        bit acc;
        acc = 1'b0;
        if (gaps > 0) begin
            s_valid = 1'b0;
            repeat (gaps) tick();
        end
        s_valid = 1'b1;
        s_data  = d;
        exp_q.push_back({addr, d});
        for (int t = 0; t < 20 && !acc; t++) begin
            @(negedge clk);
            acc = s_ready;
            tick();
        end
        if (!acc) begin
            n_checks++;
            $display("FAIL send_timeout: got no handshake, expected one within 20 cycles (addr 0x%0h)", addr);
        end
    endtask

    function automatic int pick_gap(input int mode);
        if (mode == 1) return 1;
        if (mode == 2) return ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
        return 0;
    endfunction

    // mode 0: x=i, w=k+0x100, no gaps; mode 1: same data, s_valid 1010...; mode 2: random data and gaps
    task automatic load_pass(input int mode, input int w_stop, input bit pulse_done);
        logic [63:0] d;
        pass_id++;
        for (int i = 0; i < N; i++) begin
            d = (mode == 2) ? {$urandom, $urandom} : 64'(i);
            xs[i] = d;
            if (pulse_done && i == 3) ntt_done = 1'b1;
            send_word(15'((X_BASE + i) * 4), d, pick_gap(mode));
            ntt_done = 1'b0;
        end
        for (int k = 0; k < w_stop; k++) begin
            d = (mode == 2) ? {$urandom, $urandom} : 64'(k + 'h100);
            ws[k] = d;
            if (pulse_done && (k == 50 || k == 90)) ntt_done = 1'b1;
            send_word(15'((W_BASE + k) * 4), d, pick_gap(mode));
            ntt_done = 1'b0;
        end
    endtask

    task automatic finish_load(input int mode);
        int mism;
        // Junk presented while the block must not accept: any write would be unexpected.
        s_data = 64'hDEAD_BEEF_0BAD_F00D;
        check("ntt_start_pulse", ntt_start, 1'b1);
        check("s_ready_in_start", s_ready, 1'b0);
        tick();
        check("ntt_start_single", ntt_start, 1'b0);
        check("s_ready_in_wait", s_ready, 1'b0);
        check("busy_in_wait", busy, 1'b1);
        repeat (3) tick();
        s_valid = 1'b0;
        tick();
        check("write_count", n_writes, N + NW);
        check("start_after_last_write", start_cyc, last_w_cyc + 1);
        check("start_pulses", n_starts, 1);
        if (mode == 0) check("write_span", last_w_cyc - first_w_cyc, N + NW - 1);
        if (mode == 1) check("write_span_gapped", last_w_cyc - first_w_cyc, 2 * (N + NW - 1));
        if (mode != 2) begin
            check("x5_at_addr20", mem[20 >> 2], 64'd5);
            check("w0_at_addr512", mem[512 >> 2], 64'h100);
            check("w4095_at_addr16892", mem[16892 >> 2], 64'(4095 + 'h100));
        end
        mism = 0;
        for (int i = 0; i < N; i++) if (mem[X_BASE + i] !== xs[i]) mism++;
        for (int k = 0; k < NW; k++) if (mem[W_BASE + k] !== ws[k]) mism++;
        check("xw_contents_mismatches", mism, 0);
    endtask

    // mode 0: y=0xA000+i with m_ready high; mode 1: random y with m_ready at ~30% duty
    task automatic read_phase(input int mode);
        logic [63:0] v;
        int first, last, idle;
        for (int i = 0; i < N; i++) begin
            v = (mode == 0) ? 64'('hA000 + i) : {$urandom, $urandom};
            pre_we  = 1'b1;
            pre_idx = 13'(Y_BASE + i);
            pre_val = v;
            exp_y_q.push_back(v);
            tick();
        end
        pre_we = 1'b0;
        check("still_waiting_for_done", busy, 1'b1);
        pass_id++;
        m_ready  = 1'b1;
        ntt_done = 1'b1;
        tick();
        ntt_done = 1'b0;
        first = -1; last = -1; idle = -1;
        for (int c = 0; c < 2000; c++) begin
            if (mode == 1) m_ready = ($urandom_range(0, 9) < 3);
            if (!busy) begin
                idle = c;
                break;
            end
            if (m_valid && first < 0) first = c;
            if (m_valid && m_ready) last = c;
            tick();
        end
        m_ready = 1'b0;
        if (mode == 0) begin
            check("first_y_latency", first, 2);
            check("y_consecutive_span", last - first, N - 1);
        end
        check("idle_after_last_pop", idle, last + 1);
        check("y_popped", n_pop, N);
        check("y_queue_drained", exp_y_q.size(), 0);
        check("outstanding_le_2", (max_out <= 2), 1'b1);
        check("m_valid_after_read", m_valid, 1'b0);
    endtask

    initial begin
        #1 rst = 1'b1;
        #3;
        check("rst_s_ready", s_ready, 1'b0);
        check("rst_m_valid", m_valid, 1'b0);
        check("rst_m_data", m_data, 64'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_ntt_start", ntt_start, 1'b0);
        check("rst_bram_ctrl", {BRAM_en, BRAM_we, BRAM_addr}, 17'd0);
        check("rst_bram_din", BRAM_din, 64'd0);
        repeat (2) tick();
        rst = 1'b0;
        check("s_ready_before_first_edge", s_ready, 1'b0);
        tick();
        check("s_ready_after_first_edge", s_ready, 1'b1);

        load_pass(0, NW, 1'b0);
        finish_load(0);
        read_phase(0);

        load_pass(1, NW, 1'b0);
        finish_load(1);
        read_phase(1);

        // Abort in the middle of LOAD_W after 100 w words, with ntt_done pulses that must be ignored.
        load_pass(2, 100, 1'b1);
        s_data = 64'hFFFF_0000_FFFF_0000;
        rst = 1'b1;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_bram_ctrl", {BRAM_en, BRAM_we, BRAM_addr}, 17'd0);
        check("abort_s_ready", s_ready, 1'b0);
        check("abort_no_start", n_starts, 0);
        check("abort_writes", n_writes, N + 100);
        repeat (3) tick();
        rst = 1'b0;
        s_valid = 1'b0;
        tick();
        check("abort_queue_empty", exp_q.size(), 0);
        check("post_abort_idle", busy, 1'b0);

        load_pass(2, NW, 1'b0);
        finish_load(2);
        read_phase(1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
